// File: rtl/mem_bank_ctrl_pkg.sv
// mem_bank_ctrl_pkg
//   Shared constants for the T35 memory paging / wait-state controller.
//   Holds the default I/O port numbers, the address-nibble constants that
//   identify the ROM and VGA RAM windows, the wait FSM state encodings and
//   a helper that sizes the wait counter.
//   The region nibbles must stay in step with the memory address decoder.
package mem_bank_ctrl_pkg;

  localparam logic [7:0] IO_PAGE_BASE_DEF = 8'h78;
  localparam logic [7:0] IO_CTRL_DEF      = 8'h7C;

  localparam logic [3:0] ROM_NIBBLE = 4'hF;
  localparam logic [3:0] VGA_NIBBLE = 4'hE;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_HOLD = 2'd2;

  // Enough bits to hold the larger wait count; never narrower than 1 bit
  // so the counter stays a legal vector when both waits are disabled.
  function automatic int wait_cnt_width(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    return (m > 0) ? $clog2(m + 1) : 1;
  endfunction

endpackage

// File: rtl/mem_bank_ctrl_wait_gen.sv
// mem_bank_ctrl_wait_gen
//   Generates the Z80 WAIT signal for slow memory regions.
//   A memory cycle starts on the rising edge of the strobe; if the access
//   hits ROM (or, failing that, VGA RAM) with a non-zero wait count, n_wait
//   is driven low for that many clocks, then held high until the strobe
//   drops.
// Ports:
//   clock    in  system clock
//   n_reset  in  asynchronous active-low reset
//   rom_hit  in  current access targets visible ROM
//   vga_hit  in  current access targets VGA RAM
//   strobe   in  memread | memwrite
//   n_wait   out registered active-low WAIT
module mem_bank_ctrl_wait_gen
  import mem_bank_ctrl_pkg::*;
#(
  parameter int WAIT_ROM = 2,
  parameter int WAIT_VGA = 1
) (
  input  logic clock,
  input  logic n_reset,
  input  logic rom_hit,
  input  logic vga_hit,
  input  logic strobe,
  output logic n_wait
);

  localparam int CNT_W = wait_cnt_width(WAIT_ROM, WAIT_VGA);

  logic             strobe_d;
  logic             start;
  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;

  assign start = strobe & ~strobe_d;

  always_ff @(posedge clock or negedge n_reset) begin
    if (!n_reset) begin
      strobe_d <= 1'b0;
    end else begin
      strobe_d <= strobe;
    end
  end

  // n_wait drops on the same edge that sees the start, so it is low for
  // exactly the loaded count; reaching a count of 1 ends the wait.
  // HOLD absorbs the rest of the access so one cycle never re-triggers.
  always_ff @(posedge clock or negedge n_reset) begin
    if (!n_reset) begin
      state  <= ST_IDLE;
      cnt    <= '0;
      n_wait <= 1'b1;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start && rom_hit && (WAIT_ROM > 0)) begin
            cnt    <= CNT_W'(WAIT_ROM);
            state  <= ST_WAIT;
            n_wait <= 1'b0;
          end else if (start && vga_hit && (WAIT_VGA > 0)) begin
            cnt    <= CNT_W'(WAIT_VGA);
            state  <= ST_WAIT;
            n_wait <= 1'b0;
          end
        end
        ST_WAIT: begin
          if (!strobe) begin
            state  <= ST_IDLE;
            n_wait <= 1'b1;
          end else if (cnt == CNT_W'(1)) begin
            state  <= ST_HOLD;
            n_wait <= 1'b1;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        ST_HOLD: begin
          if (!strobe) begin
            state <= ST_IDLE;
          end
        end
        default: begin
          state  <= ST_IDLE;
          n_wait <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: rtl/mem_bank_ctrl.sv
// mem_bank_ctrl
//   Memory paging and wait-state controller between the Z80 core and the
//   address decoder on the T35 S100 SBC. Four 16K page registers and a
//   control register are loaded by OUT instructions; the 16-bit CPU address
//   is translated into a PAGE_BITS+14 bit physical address.
// Ports:
//   clock       in  system clock
//   n_reset     in  asynchronous active-low reset
//   cpu_addr    in  CPU address ([7:0] = port number in I/O cycles)
//   cpu_dout    in  CPU data out
//   iowrite     in  I/O write strobe
//   memread     in  memory read strobe
//   memwrite    in  memory write strobe
//   phys_addr   out translated physical address
//   paging_en   out control bit 0
//   romDisable  out 1 = ROM visible to the decoder (inverse of control bit 1)
//   n_wait      out active-low Z80 WAIT
module mem_bank_ctrl
  import mem_bank_ctrl_pkg::*;
#(
  parameter logic [7:0] IO_PAGE_BASE = IO_PAGE_BASE_DEF,
  parameter logic [7:0] IO_CTRL      = IO_CTRL_DEF,
  parameter int         PAGE_BITS    = 5,
  parameter int         WAIT_ROM     = 2,
  parameter int         WAIT_VGA     = 1
) (
  input  logic                  clock,
  input  logic                  n_reset,
  input  logic [15:0]           cpu_addr,
  input  logic [7:0]            cpu_dout,
  input  logic                  iowrite,
  input  logic                  memread,
  input  logic                  memwrite,
  output logic [PAGE_BITS+13:0] phys_addr,
  output logic                  paging_en,
  output logic                  romDisable,
  output logic                  n_wait
);

  localparam int PHYS_W = PAGE_BITS + 14;

  logic [PAGE_BITS-1:0] page [4];
  logic [PAGE_BITS-1:0] sel_page;
  logic                 iow_d;
  logic                 io_fire;
  logic                 strobe;
  logic                 rom_hit;
  logic                 vga_hit;
  logic                 unused_dout;

  // Only part of the data byte feeds a page register.
  assign unused_dout = ^cpu_dout;

  // An OUT holds iowrite for several clocks; act only on its first one.
  assign io_fire = iowrite & ~iow_d;

  always_ff @(posedge clock or negedge n_reset) begin
    if (!n_reset) begin
      iow_d <= 1'b0;
    end else begin
      iow_d <= iowrite;
    end
  end

  always_ff @(posedge clock or negedge n_reset) begin
    if (!n_reset) begin
      for (int i = 0; i < 4; i++) begin
        page[i] <= PAGE_BITS'(i);
      end
      paging_en  <= 1'b0;
      romDisable <= 1'b1;
    end else if (io_fire) begin
      for (int i = 0; i < 4; i++) begin
        if (cpu_addr[7:0] == IO_PAGE_BASE + 8'(i)) begin
          page[i] <= cpu_dout[PAGE_BITS-1:0];
        end
      end
      if (cpu_addr[7:0] == IO_CTRL) begin
        paging_en  <= cpu_dout[0];
        romDisable <= ~cpu_dout[1];
      end
    end
  end

  assign sel_page = page[cpu_addr[15:14]];

  always_comb begin
    phys_addr = PHYS_W'(cpu_addr);
    if (paging_en) begin
      phys_addr = {sel_page, cpu_addr[13:0]};
    end
  end

  // Region decode uses the logical CPU address, matching the decoder.
  assign strobe  = memread | memwrite;
  assign rom_hit = (cpu_addr[15:12] == ROM_NIBBLE) && memread && romDisable;
  assign vga_hit = (cpu_addr[15:12] == VGA_NIBBLE) && strobe;

  mem_bank_ctrl_wait_gen #(
    .WAIT_ROM (WAIT_ROM),
    .WAIT_VGA (WAIT_VGA)
  ) u_wait_gen (
    .clock   (clock),
    .n_reset (n_reset),
    .rom_hit (rom_hit),
    .vga_hit (vga_hit),
    .strobe  (strobe),
    .n_wait  (n_wait)
  );

endmodule

// File: tb/tb_mem_bank_ctrl.sv
// tb_mem_bank_ctrl
//   Directed bench for mem_bank_ctrl: a table of I/O-write + address
//   vectors for the paging path, followed by hand-written sequences for the
//   wait-state generator, edge-only I/O writes and reset during a wait.
module tb_mem_bank_ctrl;

  typedef struct {
    logic        do_io;
    logic [7:0]  port;
    logic [7:0]  data;
    logic [15:0] addr;
    logic [18:0] exp_phys;
    logic        exp_paging;
    logic        exp_romdis;
  } vec_t;

  logic        clock;
  logic        n_reset;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_dout;
  logic        iowrite;
  logic        memread;
  logic        memwrite;
  logic [18:0] phys_addr;
  logic        paging_en;
  logic        romDisable;
  logic        n_wait;

  int checks;
  int failures;

  vec_t vecs [14];

  mem_bank_ctrl dut (
    .clock      (clock),
    .n_reset    (n_reset),
    .cpu_addr   (cpu_addr),
    .cpu_dout   (cpu_dout),
    .iowrite    (iowrite),
    .memread    (memread),
    .memwrite   (memwrite),
    .phys_addr  (phys_addr),
    .paging_en  (paging_en),
    .romDisable (romDisable),
    .n_wait     (n_wait)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic checkOutput(input string name, input logic [31:0] got,
                             input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic ioWrite(input logic [7:0] port, input logic [7:0] data);
    @(negedge clock);
    cpu_addr = {8'h00, port};
    cpu_dout = data;
    iowrite  = 1'b1;
    @(negedge clock);
    iowrite = 1'b0;
    @(negedge clock);
  endtask

  task automatic applyStimulus(input vec_t v);
    if (v.do_io) ioWrite(v.port, v.data);
    @(negedge clock);
    cpu_addr = v.addr;
    #1;
  endtask

  // Start one access and record n_wait on the six following negedges;
  // the first n_exp samples must be low and the rest high.
  task automatic measureWait(input string name, input logic [15:0] addr,
                             input logic is_write, input int n_exp);
    logic [5:0] got;
    logic [5:0] exp;
    @(negedge clock);
    cpu_addr = addr;
    memread  = ~is_write;
    memwrite = is_write;
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      got[i] = n_wait;
    end
    memread  = 1'b0;
    memwrite = 1'b0;
    repeat (2) @(negedge clock);
    exp = 6'h3F << n_exp;
    checkOutput(name, 32'(got), 32'(exp));
  endtask

  initial begin
    logic [5:0] got;

    checks   = 0;
    failures = 0;
    n_reset  = 1'b0;
    cpu_addr = 16'h0000;
    cpu_dout = 8'h00;
    iowrite  = 1'b0;
    memread  = 1'b0;
    memwrite = 1'b0;

    vecs[0]  = '{1'b0, 8'h00, 8'h00, 16'h4123, 19'h04123, 1'b0, 1'b1};
    vecs[1]  = '{1'b0, 8'h00, 8'h00, 16'hFFFF, 19'h0FFFF, 1'b0, 1'b1};
    vecs[2]  = '{1'b1, 8'h7A, 8'h15, 16'h8ABC, 19'h08ABC, 1'b0, 1'b1};
    vecs[3]  = '{1'b1, 8'h7C, 8'h01, 16'h8ABC, 19'h54ABC, 1'b1, 1'b1};
    vecs[4]  = '{1'b0, 8'h00, 8'h00, 16'h0ABC, 19'h00ABC, 1'b1, 1'b1};
    vecs[5]  = '{1'b0, 8'h00, 8'h00, 16'hBFFF, 19'h57FFF, 1'b1, 1'b1};
    vecs[6]  = '{1'b1, 8'h7B, 8'h1F, 16'hFFFF, 19'h7FFFF, 1'b1, 1'b1};
    vecs[7]  = '{1'b1, 8'h78, 8'h0A, 16'h0123, 19'h28123, 1'b1, 1'b1};
    vecs[8]  = '{1'b1, 8'h79, 8'hFF, 16'h4001, 19'h7C001, 1'b1, 1'b1};
    vecs[9]  = '{1'b1, 8'h7D, 8'h00, 16'h4001, 19'h7C001, 1'b1, 1'b1};
    vecs[10] = '{1'b1, 8'h77, 8'h00, 16'h0123, 19'h28123, 1'b1, 1'b1};
    vecs[11] = '{1'b1, 8'h7C, 8'h03, 16'h4001, 19'h7C001, 1'b1, 1'b0};
    vecs[12] = '{1'b1, 8'h7C, 8'h00, 16'h4001, 19'h04001, 1'b0, 1'b1};
    vecs[13] = '{1'b1, 8'h7C, 8'h01, 16'hC000, 19'h7C000, 1'b1, 1'b1};

    repeat (3) @(negedge clock);
    n_reset = 1'b1;
    @(negedge clock);

    $display("[TB] paging vector table");
    for (int i = 0; i < 14; i++) begin
      applyStimulus(vecs[i]);
      checkOutput($sformatf("vec%0d_phys", i), 32'(phys_addr), 32'(vecs[i].exp_phys));
      checkOutput($sformatf("vec%0d_paging", i), 32'(paging_en), 32'(vecs[i].exp_paging));
      checkOutput($sformatf("vec%0d_romdis", i), 32'(romDisable), 32'(vecs[i].exp_romdis));
      checkOutput($sformatf("vec%0d_nwait", i), 32'(n_wait), 32'h1);
    end

    $display("[TB] wait-state sequences");
    measureWait("rom_read_wait", 16'hF000, 1'b0, 2);
    ioWrite(8'h7C, 8'h02);
    checkOutput("rom_hidden_romdis", 32'(romDisable), 32'h0);
    measureWait("rom_hidden_nowait", 16'hF000, 1'b0, 0);
    measureWait("vga_write_wait", 16'hE010, 1'b1, 1);
    measureWait("plain_write_nowait", 16'h1000, 1'b1, 0);
    measureWait("vga_read_wait", 16'hEFFF, 1'b0, 1);
    measureWait("below_vga_nowait", 16'hDFFF, 1'b0, 0);

    // Strobe dropped in the middle of a ROM wait
    ioWrite(8'h7C, 8'h01);
    @(negedge clock);
    cpu_addr = 16'hF000;
    memread  = 1'b1;
    @(negedge clock);
    checkOutput("abort_first_low", 32'(n_wait), 32'h0);
    memread = 1'b0;
    @(negedge clock);
    checkOutput("abort_released", 32'(n_wait), 32'h1);
    @(negedge clock);
    checkOutput("abort_stays_high", 32'(n_wait), 32'h1);

    // I/O write and ROM read in the same cycle act independently
    @(negedge clock);
    cpu_addr = 16'hF07A;
    cpu_dout = 8'h09;
    iowrite  = 1'b1;
    memread  = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      iowrite = 1'b0;
      got[i]  = n_wait;
    end
    memread = 1'b0;
    repeat (2) @(negedge clock);
    checkOutput("simul_wait", 32'(got), 32'h3C);
    cpu_addr = 16'h8000;
    #1;
    checkOutput("simul_page2", 32'(phys_addr), 32'h24000);

    // iowrite held for several clocks: only the leading edge writes
    @(negedge clock);
    cpu_addr = 16'h0079;
    cpu_dout = 8'h03;
    iowrite  = 1'b1;
    repeat (2) @(negedge clock);
    cpu_dout = 8'h07;
    repeat (3) @(negedge clock);
    iowrite = 1'b0;
    @(negedge clock);
    cpu_addr = 16'h4000;
    #1;
    checkOutput("held_iow_page1", 32'(phys_addr), 32'h0C000);

    // Reset asserted while the ROM wait is active
    @(negedge clock);
    cpu_addr = 16'hF000;
    memread  = 1'b1;
    @(negedge clock);
    checkOutput("rst_wait_low", 32'(n_wait), 32'h0);
    #2;
    n_reset = 1'b0;
    #1;
    checkOutput("rst_nwait_async", 32'(n_wait), 32'h1);
    checkOutput("rst_paging", 32'(paging_en), 32'h0);
    checkOutput("rst_romdis", 32'(romDisable), 32'h1);
    memread = 1'b0;
    @(negedge clock);
    n_reset = 1'b1;
    ioWrite(8'h7C, 8'h01);
    cpu_addr = 16'h8ABC;
    #1;
    checkOutput("rst_page2_identity", 32'(phys_addr), 32'h08ABC);
    cpu_addr = 16'h4000;
    #1;
    checkOutput("rst_page1_identity", 32'(phys_addr), 32'h04000);
    checkOutput("rst_nwait_idle", 32'(n_wait), 32'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
